// File: rtl/reaction_pkg.sv
// Shared types and default constants for the reaction-game match referee.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TIMING = 2'd1,
        RESULT = 2'd2,
        OVER   = 2'd3
    } sb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2
    } player_e;

    localparam int unsigned DEF_TARGET_SCORE   = 5;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 500;

endpackage

// File: rtl/reaction_scoreboard_rise_detect.sv
// Single-bit rising-edge detector: registered previous value, combinational rise.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= 1'b0;
        else          prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/reaction_scoreboard.sv
// Match referee for the two-player reaction game: round timing, scores, match result.
// Optional best-time tracking is enabled by defining REACTION_SCOREBOARD_BEST_TIME_EN.
//
// state  | meaning
// IDLE   | waiting for start_led with both win LEDs low
// TIMING | round armed, counting cycles until a win rise or timeout
// RESULT | round scored, waiting for both win LEDs to drop
// OVER   | a player reached the target score; LEDs ignored until clear
module reaction_scoreboard
    import reaction_pkg::*;
#(
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned TARGET_SCORE   = DEF_TARGET_SCORE,
    parameter int unsigned TIME_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_led,
    input  logic               win1_led,
    input  logic               win2_led,
    input  logic               clear_match,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [TIME_W-1:0]  last_time,
    output logic               last_valid,
    output logic [TIME_W-1:0]  best_time,
    output logic               round_void,
    output logic               match_over,
    output logic [1:0]         match_winner
);

    localparam logic [SCORE_W-1:0] TARGET_M1 = SCORE_W'(TARGET_SCORE - 1);
    localparam logic [TIME_W-1:0]  TIMEOUT_T = TIME_W'(TIMEOUT_CYCLES);

    sb_state_e          state;
    player_e            winner_q;
    logic [TIME_W-1:0]  timer;
    logic [TIME_W-1:0]  timer_nxt;
    logic               rise1;
    logic               rise2;
    logic               armed;
    logic               score_event;

    rise_detect u_rise1 (.clk(clk), .reset_n(reset_n), .d(win1_led), .rise(rise1));
    rise_detect u_rise2 (.clk(clk), .reset_n(reset_n), .d(win2_led), .rise(rise2));

    assign armed       = start_led & ~win1_led & ~win2_led;
    assign timer_nxt   = timer + TIME_W'(1);
    assign score_event = (state == TIMING) && (rise1 || rise2) && !clear_match;
    assign match_winner = winner_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            score1     <= '0;
            score2     <= '0;
            last_time  <= '0;
            last_valid <= 1'b0;
            round_void <= 1'b0;
            match_over <= 1'b0;
            winner_q   <= NONE;
        end else begin
            last_valid <= 1'b0;
            round_void <= 1'b0;
            if (clear_match) begin
                state      <= IDLE;
                score1     <= '0;
                score2     <= '0;
                match_over <= 1'b0;
                winner_q   <= NONE;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state <= TIMING;
                            timer <= '0;
                        end
                    end
                    TIMING: begin
                        timer <= timer_nxt;
                        if (rise1 || rise2) begin
                            last_time  <= timer_nxt;
                            last_valid <= 1'b1;
                            state      <= RESULT;
                            // Player 1 takes a simultaneous rise.
                            if (rise1) begin
                                score1 <= score1 + SCORE_W'(1);
                                if (score1 == TARGET_M1) begin
                                    state      <= OVER;
                                    match_over <= 1'b1;
                                    winner_q   <= P1;
                                end
                            end else begin
                                score2 <= score2 + SCORE_W'(1);
                                if (score2 == TARGET_M1) begin
                                    state      <= OVER;
                                    match_over <= 1'b1;
                                    winner_q   <= P2;
                                end
                            end
                        end else if (timer_nxt == TIMEOUT_T) begin
                            round_void <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                    RESULT: begin
                        if (!win1_led && !win2_led) state <= IDLE;
                    end
                    OVER: begin
                        state <= OVER;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef REACTION_SCOREBOARD_BEST_TIME_EN
    logic [TIME_W-1:0] best_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_q <= '1;
        end else if (clear_match) begin
            best_q <= '1;
        end else if (score_event && (timer_nxt < best_q)) begin
            best_q <= timer_nxt;
        end
    end

    assign best_time = best_q;
`else
    logic unused_score_event;
    assign unused_score_event = score_event;
    assign best_time = '1;
`endif

endmodule

// File: doc/reaction_scoreboard.md
# reaction_scoreboard

Match referee for the two-player reaction game. Sits downstream of the game core and consumes its `start_led` / `win1_led` / `win2_led` outputs. Decodes round boundaries and winners, measures each winner's reaction time in clock cycles, keeps per-player scores, and declares a match winner when a player reaches the target score.

## Interface
Parameters:
- `SCORE_W`, default 4: width of each score counter.
- `TARGET_SCORE`, default 5: score that ends the match. Must satisfy 1 ≤ value ≤ 2^SCORE_W−1.
- `TIME_W`, default 32: width of the reaction-time values.
- `TIMEOUT_CYCLES`, default 500: cycles in TIMING with no winner before the round is voided. Must satisfy 1 ≤ value < 2^TIME_W.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_led` in 1: round-armed indication from the game core.
- `win1_led` in 1: player 1 won the round.
- `win2_led` in 1: player 2 won the round.
- `clear_match` in 1: synchronous, level-sampled. Clears scores and the match result.
- `score1` out SCORE_W: player 1 score.
- `score2` out SCORE_W: player 2 score.
- `last_time` out TIME_W: reaction time of the most recent scored round.
- `last_valid` out 1: one-cycle pulse when `last_time` / score update.
- `best_time` out TIME_W: smallest `last_time` since reset or clear.
- `round_void` out 1: one-cycle pulse when a round times out.
- `match_over` out 1: level. A player has reached `TARGET_SCORE`.
- `match_winner` out 2: 0 = none, 1 = player 1, 2 = player 2.

## Operation
- Rising-edge detect on `win1_led` and `win2_led`. Each uses a previous-value register that resets to 0.
- Armed condition: `start_led`=1 and `win1_led`=0 and `win2_led`=0, all in the same sample.
- States are IDLE, TIMING, RESULT and OVER.
  - IDLE: if armed is sampled, go to TIMING and set timer to 0.
  - TIMING: timer increments each cycle.
    - On a win rise, capture `last_time`=timer+1, increment the winner's score, pulse `last_valid`, then go to RESULT, or to OVER if the new score equals `TARGET_SCORE`.
    - If timer+1 reaches `TIMEOUT_CYCLES` with no win rise, pulse `round_void` and go to IDLE. The round re-arms the next cycle if the armed condition still holds.
  - RESULT: wait until `win1_led`=0 and `win2_led`=0 are both sampled, then go to IDLE.
  - OVER: `match_over`=1 and `match_winner` is held. All LED activity is ignored.
- Simultaneous win1 and win2 rise: player 1 is credited and player 2 is ignored.
- A win rise in IDLE or RESULT is ignored. No score or time is recorded.
- Best time: if `last_time` < `best_time`, it replaces `best_time`, on the same edge as the `last_time` update.
- `clear_match`=1 in any state, on the next edge:
  - scores go to 0, `best_time` to all-ones, `match_over` to 0 and `match_winner` to 0;
  - the state goes to IDLE and any pending win in that cycle is discarded;
  - `last_time` is kept.
- Scores never exceed `TARGET_SCORE`, so no wrap is possible.

## Timing
- Reset values:
  - state IDLE;
  - `score1`, `score2`, `last_time` = 0;
  - `best_time` = all-ones;
  - `last_valid`, `round_void`, `match_over` = 0;
  - `match_winner` = 0;
  - edge registers = 0.
- Measured value: if armed is sampled at edge k and the win rise at edge k+d, then `last_time`=d. The minimum is 1.
- Latency: all outputs are registered. A win rise sampled at edge N is visible on the outputs after edge N, and `last_valid` is high for exactly that one cycle.
- `round_void` is high for the cycle after edge k+`TIMEOUT_CYCLES`.
- Reset asserted mid-round returns every output to its reset value immediately, regardless of `clk`.

## Configuration
- `REACTION_SCOREBOARD_BEST_TIME_EN` defined: best-time comparator and register are compiled in, as described above.
- Undefined: no comparator or register. `best_time` is driven constantly to all-ones and the port list is unchanged.

## Structure
- Shared package `reaction_pkg` holds:
  - the `sb_state_e` enum (IDLE, TIMING, RESULT, OVER);
  - the `player_e` 2-bit encoding (NONE=0, P1=1, P2=2), used for `match_winner`;
  - default constants for `TARGET_SCORE` and `TIMEOUT_CYCLES`.
- Sub-module `rise_detect`: single-bit registered edge detector with async active-low reset. It is instantiated for `win1_led` and `win2_led`.

## Test plan
- Reset, then start_led=1 sampled at edge 10, win1_led rising sampled at edge 17 → after edge 17: `last_time`=7, `score1`=1, `last_valid` for one cycle, `best_time`=7.
- win1_led and win2_led rise in the same cycle → `score1`+1, `score2` unchanged.
- start_led=1 with no win for 500 cycles → one `round_void` pulse after edge k+500, scores unchanged, re-arm on the next cycle.
- Player 2 wins 5 rounds (TARGET_SCORE=5) → `match_over`=1, `match_winner`=2. A further win1 rise leaves `score1` unchanged. `clear_match` → all scores 0, `match_winner`=0, IDLE.
- Times of 9 then 4 then 12 → `best_time` 9, 4, 4. With the macro undefined, `best_time` stays all-ones.
- `reset_n` dropped during TIMING → all outputs return to their reset values asynchronously. The next round measures from a fresh armed sample.
